// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that time-shares one bitwise logic unit (OR/AND/XOR/NAND)
// among NREQ requesters, with a valid/ready request side and a held, tagged response.
module logic_unit_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [2*NREQ-1:0]          req_op,
  input  logic [WIDTH*NREQ-1:0]      req_inA,
  input  logic [WIDTH*NREQ-1:0]      req_inB,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]           rsp_out,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_out_q, rsp_out_d;

  logic               grant_found_s;
  logic [IDW-1:0]     grant_idx_s;
  logic [NREQ-1:0]    ready_s;

  // Bitwise function of the shared logic array: 00 OR, 01 AND, 10 XOR, 11 NAND.
  function automatic logic [WIDTH-1:0] logic_fn(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a | b;
      2'b01:   r = a & b;
      2'b10:   r = a ^ b;
      2'b11:   r = ~(a & b);
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {IDW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found_s && req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Only the granted requester sees ready, and only while idle and out of reset.
  always_comb begin
    ready_s = {NREQ{1'b0}};
    if (reset_n && (state_q == ST_IDLE) && grant_found_s) begin
      ready_s[grant_idx_s] = 1'b1;
    end else begin
      ready_s = {NREQ{1'b0}};
    end
  end

  // Next-state logic for the IDLE -> EXEC -> RESP sequencer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          op_d     = req_op[2*int'(grant_idx_s) +: 2];
          a_d      = req_inA[WIDTH*int'(grant_idx_s) +: WIDTH];
          b_d      = req_inB[WIDTH*int'(grant_idx_s) +: WIDTH];
          id_d     = grant_idx_s;
          rr_ptr_d = IDW'((int'(grant_idx_s) + 1) % NREQ);
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_EXEC: begin
        rsp_out_d   = logic_fn(op_q, a_q, b_q);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Returning to IDLE here means no accept can coincide with the response handshake.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State, captured operation and response registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= {IDW{1'b0}};
      op_q        <= 2'b00;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      id_q        <= {IDW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {IDW{1'b0}};
      rsp_out_q   <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
    end
  end

  assign req_ready = ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed, table-driven bench for logic_unit_arbiter: grant order, results,
// latency, back-pressure, operand isolation and asynchronous reset.
module tb_logic_unit_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_inA;
  logic [31:0] req_inB;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_out;
  logic        busy;

  int total;
  int bad;

  typedef struct {
    logic [3:0] vld;
    logic [7:0] ops;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] exp_rdy;
    logic [7:0] exp_out;
    logic [1:0] exp_id;
  } vec_t;

  vec_t tbl[12];

  logic_unit_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_inA   (req_inA),
    .req_inB   (req_inB),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[2*i +: 2]  = op;
    req_inA[8*i +: 8] = a;
    req_inB[8*i +: 8] = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // One full transaction with rsp_ready high: accept, EXEC, RESP, handshake.
  task automatic run_op(input logic [3:0] vld, input logic [3:0] exp_rdy,
                        input logic [7:0] exp_out, input logic [1:0] exp_id);
    rsp_ready = 1'b1;
    req_valid = vld;
    #1;
    check("accept_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
    check("idle_busy", {31'd0, busy}, 32'd0);
    step();
    check("exec_ready", {28'd0, req_ready}, 32'd0);
    check("exec_busy", {31'd0, busy}, 32'd1);
    check("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    check("resp_valid", {31'd0, rsp_valid}, 32'd1);
    check("resp_out", {24'd0, rsp_out}, {24'd0, exp_out});
    check("resp_id", {30'd0, rsp_id}, {30'd0, exp_id});
    check("resp_ready_low", {28'd0, req_ready}, 32'd0);
    step();
    check("done_valid", {31'd0, rsp_valid}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;

    tbl[0]  = '{4'b1111, 8'b11100100, 8'hA5, 8'h0F, 4'b0001, 8'hAF, 2'd0};
    tbl[1]  = '{4'b1111, 8'b11100100, 8'hA5, 8'h0F, 4'b0010, 8'h05, 2'd1};
    tbl[2]  = '{4'b1111, 8'b11100100, 8'hA5, 8'h0F, 4'b0100, 8'hAA, 2'd2};
    tbl[3]  = '{4'b1111, 8'b11100100, 8'hA5, 8'h0F, 4'b1000, 8'hFA, 2'd3};
    tbl[4]  = '{4'b1111, 8'b11100100, 8'hA5, 8'h0F, 4'b0001, 8'hAF, 2'd0};
    tbl[5]  = '{4'b0001, 8'h00,       8'h00, 8'h00, 4'b0001, 8'h00, 2'd0};
    tbl[6]  = '{4'b1000, 8'hFF,       8'hFF, 8'hFF, 4'b1000, 8'h00, 2'd3};
    tbl[7]  = '{4'b0110, 8'hAA,       8'h3C, 8'hFF, 4'b0010, 8'hC3, 2'd1};
    tbl[8]  = '{4'b0110, 8'h55,       8'hF0, 8'hFF, 4'b0100, 8'hF0, 2'd2};
    tbl[9]  = '{4'b0011, 8'h00,       8'h12, 8'h48, 4'b0001, 8'h5A, 2'd0};
    tbl[10] = '{4'b0001, 8'hFF,       8'h00, 8'h00, 4'b0001, 8'hFF, 2'd0};
    tbl[11] = '{4'b0001, 8'hAA,       8'h81, 8'h18, 4'b0001, 8'h99, 2'd0};

    reset_n   = 1'b0;
    req_valid = 4'b0100;
    req_op    = 8'h00;
    req_inA   = 32'h0;
    req_inB   = 32'h0;
    rsp_ready = 1'b0;
    set_req(2, 2'b01, 8'hF0, 8'h3C);
    step();
    step();
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_out", {24'd0, rsp_out}, 32'd0);
    check("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset_n = 1'b1;

    // Requester 2 alone right after reset, then pointer sits at 3.
    run_op(4'b0100, 4'b0100, 8'h30, 2'd2);
    set_req(3, 2'b10, 8'h0F, 8'hFF);
    run_op(4'b1001, 4'b1000, 8'hF0, 2'd3);
    set_req(0, 2'b00, 8'h01, 8'h02);
    run_op(4'b0011, 4'b0001, 8'h03, 2'd0);
    req_valid = 4'b0000;

    do_reset();
    for (int i = 0; i < 12; i++) begin
      req_op  = tbl[i].ops;
      req_inA = {4{tbl[i].a}};
      req_inB = {4{tbl[i].b}};
      run_op(tbl[i].vld, tbl[i].exp_rdy, tbl[i].exp_out, tbl[i].exp_id);
    end

    // Back-pressure: response held while requester 1 waits.
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    set_req(0, 2'b00, 8'h55, 8'hAA);
    set_req(1, 2'b01, 8'hFF, 8'h0F);
    req_valid = 4'b0001;
    #1;
    check("bp_accept0", {28'd0, req_ready}, 32'd1);
    step();
    req_valid = 4'b0010;
    step();
    check("bp_valid", {31'd0, rsp_valid}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_hold_out", {24'd0, rsp_out}, 32'hFF);
      check("bp_hold_id", {30'd0, rsp_id}, 32'd0);
      check("bp_hold_ready", {28'd0, req_ready}, 32'd0);
      check("bp_hold_busy", {31'd0, busy}, 32'd1);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_released", {31'd0, rsp_valid}, 32'd0);
    run_op(4'b0010, 4'b0010, 8'h0F, 2'd1);

    // Operands change after acceptance must not affect the result.
    req_valid = 4'b0000;
    set_req(0, 2'b00, 8'h00, 8'h01);
    req_valid = 4'b0001;
    #1;
    check("opchg_accept", {28'd0, req_ready}, 32'd1);
    step();
    set_req(0, 2'b00, 8'hFF, 8'h01);
    req_valid = 4'b0000;
    step();
    check("opchg_valid", {31'd0, rsp_valid}, 32'd1);
    check("opchg_out", {24'd0, rsp_out}, 32'h01);
    check("opchg_id", {30'd0, rsp_id}, 32'd0);
    step();

    // Asynchronous reset while a response is pending.
    rsp_ready = 1'b0;
    set_req(2, 2'b01, 8'hFF, 8'hFF);
    req_valid = 4'b0100;
    #1;
    check("ar_accept", {28'd0, req_ready}, 32'h4);
    step();
    req_valid = 4'b0000;
    step();
    check("ar_pre_valid", {31'd0, rsp_valid}, 32'd1);
    check("ar_pre_out", {24'd0, rsp_out}, 32'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", {31'd0, rsp_valid}, 32'd0);
    check("ar_out", {24'd0, rsp_out}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    step();
    step();
    reset_n = 1'b1;
    check("ar_no_rsp", {31'd0, rsp_valid}, 32'd0);
    set_req(0, 2'b10, 8'h0F, 8'h33);
    set_req(1, 2'b00, 8'h11, 8'h22);
    run_op(4'b0011, 4'b0001, 8'h3C, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Round-robin arbiter and sequencer that time-shares one 8-bit bitwise logic unit (OR/AND/XOR/NAND, built from the per-bit gate cells) among four requesters. It accepts one operation at a time over a valid/ready handshake, computes it in a dedicated cycle, and holds the tagged result until the consumer takes it. It sits between the requesting datapath blocks and the shared gate-level logic array.

Parameters:
WIDTH, 8, operand and result width in bits
NREQ, 4, number of requesters; rsp_id width is log2(NREQ)

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  per-requester accept; at most one bit high
req_op  input  2*NREQ  op for requester i in bits [2i+1:2i]; 00 OR, 01 AND, 10 XOR, 11 NAND
req_inA  input  WIDTH*NREQ  operand A for requester i in bits [WIDTH*i+WIDTH-1:WIDTH*i]
req_inB  input  WIDTH*NREQ  operand B for requester i, same packing
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_id  output  2  index of the requester that owns the result
rsp_out  output  WIDTH  result word
busy  output  1  high in EXEC and RESP

Behaviour:
- Reset is asynchronous and active-low. While reset_n is low: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_out=0, busy=0, req_ready=0, and the captured op and operand registers are 0.
- FSM states: IDLE, EXEC and RESP.
- IDLE:
  - req_ready is combinational. The requester granted is the first i with req_valid[i]=1, searching from rr_ptr upward with wrap-around (rr_ptr, rr_ptr+1, ..., modulo NREQ).
  - Only the granted requester sees req_ready=1. If no req_valid bit is set, req_ready=0 and the block stays in IDLE.
  - A transfer happens when req_valid[g] and req_ready[g] are both high. On that edge: capture op, inA and inB for g; set id_reg=g; set rr_ptr=(g+1) mod NREQ; go to EXEC.
- EXEC:
  - req_ready=0.
  - On the next edge, rsp_out <= f(op, inA, inB) bitwise over all WIDTH bits, rsp_id <= id_reg, rsp_valid <= 1; go to RESP.
  - The function is OR (a|b), AND (a&b), XOR (a^b) or NAND (~(a&b)).
- RESP:
  - req_ready=0. rsp_valid, rsp_id and rsp_out are held stable until rsp_valid and rsp_ready are both high.
  - On that edge: rsp_valid <= 0 and go to IDLE. rsp_out and rsp_id keep their last value.
  - No new request is accepted in the same cycle as the response handshake.
- Latency and throughput:
  - With a request accepted at edge N, rsp_valid is high after edge N+1.
  - With rsp_ready tied high, the response completes at edge N+2, so the next accept is at edge N+3. Maximum throughput is one op per 3 cycles.
- Fairness:
  - A requester holding req_valid high is granted within NREQ grants.
  - If only one requester is active, it is granted every time.
- Requesters may drop req_valid without a transfer. Operands are sampled only on the transfer edge; later input changes do not affect the result.
- busy = (state != IDLE).
- If reset is asserted during EXEC or RESP, the in-flight op is discarded, no response is produced, and rr_ptr returns to 0.
- Boundary cases:
  - All four requesters valid from reset: grants go 0, 1, 2, 3, 0, ...
  - If rr_ptr=3 and only requester 0 is valid, the search wraps and grants 0.

Test Plan:
- Reset, then requester 2 only: op=01, inA=0xF0, inB=0x3C. Required: req_ready=0100 in the accept cycle; rsp_valid high 2 edges after reset release, 0x30, rsp_id=2; then rr_ptr=3.
- All four valid continuously with rsp_ready=1; req i uses op=i, inA=0xA5, inB=0x0F. Required: grant order 0, 1, 2, 3, 0; results OR 0xAF, AND 0x05, XOR 0xAA, NAND 0xFA; one accept every 3 cycles.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid. Required: rsp_out, rsp_id and rsp_valid remain stable; req_ready stays 0 although req_valid[1]=1; requester 1 is granted the cycle after rsp_ready rises and its response completes.
- Wrap: after a grant to requester 3, assert only req_valid[0] and req_valid[1]. Required: requester 0 is granted first.
- Operands change after acceptance: inA changes from 0x00 to 0xFF in EXEC, op=00, inB=0x01. Required: rsp_out=0x01.
- Reset asserted asynchronously in RESP with rsp_valid=1. Required: rsp_valid, rsp_out and busy go to 0 immediately; after release, requester 0 wins against requester 1.
